// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, opcode constants and helpers for the ALU
// reservation station. The optional macro RS_WAKEUP_BYPASS_EN is consumed by
// alu_rs.sv; nothing in this package depends on it.
package alu_rs_pkg;

  // Width of ROB tags used on dispatch, CDB and ALU request interfaces
  localparam int ROB_SIZE_WIDTH = 4;

  // Default number of reservation-station entries
  localparam int RS_SIZE_DEFAULT = 8;

  // Entry field widths
  localparam int OP_W    = 3;
  localparam int ITYPE_W = 7;
  localparam int DATA_W  = 32;

  // Opcodes accepted by this station
  localparam logic [ITYPE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [ITYPE_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [ITYPE_W-1:0] OP_BRANCH = 7'b1100011;

  // When both buses carry the same tag (an upstream bug) the ALU bus wins
  function automatic logic [DATA_W-1:0] cdb_pick(
    input logic              alu_hit,
    input logic [DATA_W-1:0] alu_result,
    input logic [DATA_W-1:0] lsb_result
  );
    return alu_hit ? alu_result : lsb_result;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// alu_rs_select: lowest-index priority encoders for the reservation station.
// One encoder finds the first free slot, the other the first ready slot.
module alu_rs_select
  import alu_rs_pkg::*;
#(
  parameter int N     = RS_SIZE_DEFAULT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     busy,
  input  logic [N-1:0]     ready,
  output logic [IDX_W-1:0] free_idx,
  output logic             free_found,
  output logic [IDX_W-1:0] issue_idx,
  output logic             issue_found
);

  // Scan from the top down so the lowest matching index is the last one written
  always_comb begin
    free_idx    = '0;
    free_found  = 1'b0;
    issue_idx   = '0;
    issue_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
      if (ready[i]) begin
        issue_idx   = IDX_W'(i);
        issue_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station. Holds dispatched integer/branch ops until
// both operands are known (snooping the ALU and LSB CDBs), then issues one
// ready op per cycle as a registered ALU request.
// Optional macro RS_WAKEUP_BYPASS_EN: an operand whose producer broadcasts
// this cycle counts as ready and is muxed straight from the CDB at issue.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEFAULT,
  parameter int ROB_W   = ROB_SIZE_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               rob_clear,
  input  logic               disp_valid,
  input  logic [ROB_W-1:0]   disp_rob_id,
  input  logic [OP_W-1:0]    disp_op,
  input  logic [ITYPE_W-1:0] disp_instr_type,
  input  logic               disp_op_other,
  input  logic               disp_qj_pending,
  input  logic               disp_qk_pending,
  input  logic [ROB_W-1:0]   disp_qj,
  input  logic [ROB_W-1:0]   disp_qk,
  input  logic [DATA_W-1:0]  disp_vj,
  input  logic [DATA_W-1:0]  disp_vk,
  output logic               full,
  input  logic               cdb_alu_valid,
  input  logic [ROB_W-1:0]   cdb_alu_rob_id,
  input  logic [DATA_W-1:0]  cdb_alu_result,
  input  logic               cdb_lsb_valid,
  input  logic [ROB_W-1:0]   cdb_lsb_rob_id,
  input  logic [DATA_W-1:0]  cdb_lsb_result,
  output logic               alu_valid,
  output logic [ROB_W-1:0]   alu_rob_id,
  output logic [OP_W-1:0]    alu_op,
  output logic [ITYPE_W-1:0] alu_instr_type,
  output logic               alu_op_other,
  output logic [DATA_W-1:0]  alu_v1,
  output logic [DATA_W-1:0]  alu_v2
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage
  logic [RS_SIZE-1:0] busy_reg;
  logic [RS_SIZE-1:0] qj_pending_reg;
  logic [RS_SIZE-1:0] qk_pending_reg;
  logic [RS_SIZE-1:0] op_other_reg;
  logic [ROB_W-1:0]   rob_id_reg     [RS_SIZE];
  logic [OP_W-1:0]    op_reg         [RS_SIZE];
  logic [ITYPE_W-1:0] instr_type_reg [RS_SIZE];
  logic [ROB_W-1:0]   qj_reg         [RS_SIZE];
  logic [ROB_W-1:0]   qk_reg         [RS_SIZE];
  logic [DATA_W-1:0]  vj_reg         [RS_SIZE];
  logic [DATA_W-1:0]  vk_reg         [RS_SIZE];

  // Per-entry wakeup and operand-view signals
  logic [RS_SIZE-1:0] qj_alu_hit, qj_hit, qk_alu_hit, qk_hit;
  logic [DATA_W-1:0]  qj_cdb_val [RS_SIZE];
  logic [DATA_W-1:0]  qk_cdb_val [RS_SIZE];
  logic [DATA_W-1:0]  vj_eff     [RS_SIZE];
  logic [DATA_W-1:0]  vk_eff     [RS_SIZE];
  logic [RS_SIZE-1:0] ready;

  logic [IDX_W-1:0] free_idx, issue_idx;
  logic             free_found, issue_found;

  // Dispatch-time CDB forwarding
  logic              disp_qj_alu_hit, disp_qj_hit, disp_qk_alu_hit, disp_qk_hit;
  logic [DATA_W-1:0] disp_vj_next, disp_vk_next;
  logic              disp_fire;

  // Registered ALU request
  logic               alu_valid_reg;
  logic [ROB_W-1:0]   alu_rob_id_reg;
  logic [OP_W-1:0]    alu_op_reg;
  logic [ITYPE_W-1:0] alu_instr_type_reg;
  logic               alu_op_other_reg;
  logic [DATA_W-1:0]  alu_v1_reg, alu_v2_reg;

  // Forward a just-broadcast value into the entry being dispatched
  always_comb begin
    disp_qj_alu_hit = cdb_alu_valid && (disp_qj == cdb_alu_rob_id);
    disp_qj_hit     = disp_qj_pending &&
                      (disp_qj_alu_hit || (cdb_lsb_valid && (disp_qj == cdb_lsb_rob_id)));
    disp_qk_alu_hit = cdb_alu_valid && (disp_qk == cdb_alu_rob_id);
    disp_qk_hit     = disp_qk_pending &&
                      (disp_qk_alu_hit || (cdb_lsb_valid && (disp_qk == cdb_lsb_rob_id)));
    disp_vj_next    = disp_qj_hit ? cdb_pick(disp_qj_alu_hit, cdb_alu_result, cdb_lsb_result)
                                  : disp_vj;
    disp_vk_next    = disp_qk_hit ? cdb_pick(disp_qk_alu_hit, cdb_alu_result, cdb_lsb_result)
                                  : disp_vk;
  end

  assign full      = &busy_reg;
  assign disp_fire = disp_valid && !full;

  alu_rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_select (
    .busy        (busy_reg),
    .ready       (ready),
    .free_idx    (free_idx),
    .free_found  (free_found),
    .issue_idx   (issue_idx),
    .issue_found (issue_found)
  );

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      // Tag match of each pending operand against both broadcast buses
      always_comb begin
        qj_alu_hit[gi] = cdb_alu_valid && (qj_reg[gi] == cdb_alu_rob_id);
        qj_hit[gi]     = qj_pending_reg[gi] &&
                         (qj_alu_hit[gi] || (cdb_lsb_valid && (qj_reg[gi] == cdb_lsb_rob_id)));
        qk_alu_hit[gi] = cdb_alu_valid && (qk_reg[gi] == cdb_alu_rob_id);
        qk_hit[gi]     = qk_pending_reg[gi] &&
                         (qk_alu_hit[gi] || (cdb_lsb_valid && (qk_reg[gi] == cdb_lsb_rob_id)));
        qj_cdb_val[gi] = cdb_pick(qj_alu_hit[gi], cdb_alu_result, cdb_lsb_result);
        qk_cdb_val[gi] = cdb_pick(qk_alu_hit[gi], cdb_alu_result, cdb_lsb_result);
      end

`ifdef RS_WAKEUP_BYPASS_EN
      // Readiness and issue operands see this cycle's broadcast directly
      always_comb begin
        ready[gi]  = busy_reg[gi] && (!qj_pending_reg[gi] || qj_hit[gi])
                                  && (!qk_pending_reg[gi] || qk_hit[gi]);
        vj_eff[gi] = qj_hit[gi] ? qj_cdb_val[gi] : vj_reg[gi];
        vk_eff[gi] = qk_hit[gi] ? qk_cdb_val[gi] : vk_reg[gi];
      end
`else
      // Readiness comes from registered state only
      always_comb begin
        ready[gi]  = busy_reg[gi] && !qj_pending_reg[gi] && !qk_pending_reg[gi];
        vj_eff[gi] = vj_reg[gi];
        vk_eff[gi] = vk_reg[gi];
      end
`endif

      // Entry state: flush, dispatch write, CDB wakeup and release on issue
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          busy_reg[gi]       <= 1'b0;
          qj_pending_reg[gi] <= 1'b0;
          qk_pending_reg[gi] <= 1'b0;
          op_other_reg[gi]   <= 1'b0;
          rob_id_reg[gi]     <= '0;
          op_reg[gi]         <= '0;
          instr_type_reg[gi] <= '0;
          qj_reg[gi]         <= '0;
          qk_reg[gi]         <= '0;
          vj_reg[gi]         <= '0;
          vk_reg[gi]         <= '0;
        end else if (rdy) begin
          if (rob_clear) begin
            busy_reg[gi] <= 1'b0;
          end else if (disp_fire && (free_idx == IDX_W'(gi))) begin
            busy_reg[gi]       <= 1'b1;
            rob_id_reg[gi]     <= disp_rob_id;
            op_reg[gi]         <= disp_op;
            instr_type_reg[gi] <= disp_instr_type;
            op_other_reg[gi]   <= disp_op_other;
            qj_pending_reg[gi] <= disp_qj_pending && !disp_qj_hit;
            qj_reg[gi]         <= disp_qj;
            vj_reg[gi]         <= disp_vj_next;
            qk_pending_reg[gi] <= disp_qk_pending && !disp_qk_hit;
            qk_reg[gi]         <= disp_qk;
            vk_reg[gi]         <= disp_vk_next;
          end else if (busy_reg[gi]) begin
            if (qj_hit[gi]) begin
              qj_pending_reg[gi] <= 1'b0;
              vj_reg[gi]         <= qj_cdb_val[gi];
            end
            if (qk_hit[gi]) begin
              qk_pending_reg[gi] <= 1'b0;
              vk_reg[gi]         <= qk_cdb_val[gi];
            end
            if (issue_found && (issue_idx == IDX_W'(gi))) begin
              busy_reg[gi] <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  // Registered ALU request: load the selected entry, drop valid when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_reg      <= 1'b0;
      alu_rob_id_reg     <= '0;
      alu_op_reg         <= '0;
      alu_instr_type_reg <= '0;
      alu_op_other_reg   <= 1'b0;
      alu_v1_reg         <= '0;
      alu_v2_reg         <= '0;
    end else if (rdy) begin
      if (rob_clear) begin
        alu_valid_reg <= 1'b0;
      end else if (issue_found) begin
        alu_valid_reg      <= 1'b1;
        alu_rob_id_reg     <= rob_id_reg[issue_idx];
        alu_op_reg         <= op_reg[issue_idx];
        alu_instr_type_reg <= instr_type_reg[issue_idx];
        alu_op_other_reg   <= op_other_reg[issue_idx];
        alu_v1_reg         <= vj_eff[issue_idx];
        alu_v2_reg         <= vk_eff[issue_idx];
      end else begin
        alu_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_valid      = alu_valid_reg;
  assign alu_rob_id     = alu_rob_id_reg;
  assign alu_op         = alu_op_reg;
  assign alu_instr_type = alu_instr_type_reg;
  assign alu_op_other   = alu_op_other_reg;
  assign alu_v1         = alu_v1_reg;
  assign alu_v2         = alu_v2_reg;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios followed by random traffic, every cycle
// checked against a behavioural model of the reservation station.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N  = 8;
  localparam int RW = ROB_SIZE_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, rdy = 1'b1, rob_clear = 1'b0;
  logic          disp_valid = 1'b0, disp_op_other = 1'b0;
  logic [RW-1:0] disp_rob_id = '0, disp_qj = '0, disp_qk = '0;
  logic [2:0]    disp_op = '0;
  logic [6:0]    disp_instr_type = '0;
  logic          disp_qj_pending = 1'b0, disp_qk_pending = 1'b0;
  logic [31:0]   disp_vj = '0, disp_vk = '0;
  logic          full;
  logic          cdb_alu_valid = 1'b0, cdb_lsb_valid = 1'b0;
  logic [RW-1:0] cdb_alu_rob_id = '0, cdb_lsb_rob_id = '0;
  logic [31:0]   cdb_alu_result = '0, cdb_lsb_result = '0;
  logic          alu_valid, alu_op_other;
  logic [RW-1:0] alu_rob_id;
  logic [2:0]    alu_op;
  logic [6:0]    alu_instr_type;
  logic [31:0]   alu_v1, alu_v2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_rs #(.RS_SIZE(N), .ROB_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rob_clear(rob_clear),
    .disp_valid(disp_valid), .disp_rob_id(disp_rob_id), .disp_op(disp_op),
    .disp_instr_type(disp_instr_type), .disp_op_other(disp_op_other),
    .disp_qj_pending(disp_qj_pending), .disp_qk_pending(disp_qk_pending),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id),
    .cdb_alu_result(cdb_alu_result),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_id(cdb_lsb_rob_id),
    .cdb_lsb_result(cdb_lsb_result),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_op(alu_op),
    .alu_instr_type(alu_instr_type), .alu_op_other(alu_op_other),
    .alu_v1(alu_v1), .alu_v2(alu_v2)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          busy;
    logic [RW-1:0] rob;
    logic [2:0]  op;
    logic [6:0]  it;
    bit          oo;
    bit          jp;
    logic [RW-1:0] qj;
    logic [31:0] vj;
    bit          kp;
    logic [RW-1:0] qk;
    logic [31:0] vk;
  } ent_t;

  ent_t          m [N];
  logic          m_av, m_aoo;
  logic [RW-1:0] m_arob;
  logic [2:0]    m_aop;
  logic [6:0]    m_ait;
  logic [31:0]   m_v1, m_v2;

  function automatic bit bus_hit(input logic [RW-1:0] tag);
    return (cdb_alu_valid && cdb_alu_rob_id == tag) || (cdb_lsb_valid && cdb_lsb_rob_id == tag);
  endfunction

  function automatic logic [31:0] bus_val(input logic [RW-1:0] tag);
    return (cdb_alu_valid && cdb_alu_rob_id == tag) ? cdb_alu_result : cdb_lsb_result;
  endfunction

  function automatic bit operand_known(input bit pend, input logic [RW-1:0] tag);
`ifdef RS_WAKEUP_BYPASS_EN
    return !pend || bus_hit(tag);
`else
    return !pend;
`endif
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m[i] = '{default: '0};
    m_av = 0; m_arob = '0; m_aop = '0; m_ait = '0; m_aoo = 0; m_v1 = '0; m_v2 = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int iss = -1;
    int fre = -1;
    if (!rdy) return;
    if (rob_clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      m_av = 0;
      return;
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i].busy && operand_known(m[i].jp, m[i].qj) && operand_known(m[i].kp, m[i].qk)) iss = i;
      if (!m[i].busy) fre = i;
    end
    if (iss >= 0) begin
      m_av   = 1;
      m_arob = m[iss].rob; m_aop = m[iss].op; m_ait = m[iss].it; m_aoo = m[iss].oo;
      m_v1   = m[iss].jp ? bus_val(m[iss].qj) : m[iss].vj;
      m_v2   = m[iss].kp ? bus_val(m[iss].qk) : m[iss].vk;
    end else begin
      m_av = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && m[i].jp && bus_hit(m[i].qj)) begin m[i].vj = bus_val(m[i].qj); m[i].jp = 0; end
      if (m[i].busy && m[i].kp && bus_hit(m[i].qk)) begin m[i].vk = bus_val(m[i].qk); m[i].kp = 0; end
    end
    if (disp_valid && fre >= 0) begin
      m[fre].busy = 1; m[fre].rob = disp_rob_id; m[fre].op = disp_op;
      m[fre].it = disp_instr_type; m[fre].oo = disp_op_other;
      m[fre].qj = disp_qj; m[fre].qk = disp_qk;
      m[fre].jp = disp_qj_pending && !bus_hit(disp_qj);
      m[fre].kp = disp_qk_pending && !bus_hit(disp_qk);
      m[fre].vj = (disp_qj_pending && bus_hit(disp_qj)) ? bus_val(disp_qj) : disp_vj;
      m[fre].vk = (disp_qk_pending && bus_hit(disp_qk)) ? bus_val(disp_qk) : disp_vk;
    end
    if (iss >= 0) m[iss].busy = 0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("m_full",  32'(full), 32'(m_full()));
    check("m_valid", 32'(alu_valid), 32'(m_av));
    check("m_rob",   32'(alu_rob_id), 32'(m_arob));
    check("m_op",    32'(alu_op), 32'(m_aop));
    check("m_itype", 32'(alu_instr_type), 32'(m_ait));
    check("m_other", 32'(alu_op_other), 32'(m_aoo));
    check("m_v1",    alu_v1, m_v1);
    check("m_v2",    alu_v2, m_v2);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_disp(input int rob, input bit jp, input int qj, input int vj,
                          input bit kp, input int qk, input int vk);
    disp_valid = 1; disp_rob_id = RW'(rob); disp_op = 3'b000;
    disp_instr_type = OP_REG; disp_op_other = 0;
    disp_qj_pending = jp; disp_qj = RW'(qj); disp_vj = 32'(vj);
    disp_qk_pending = kp; disp_qk = RW'(qk); disp_vk = 32'(vk);
  endtask

  task automatic idle();
    disp_valid = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0; rob_clear = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    #12;
    check("rst_valid", 32'(alu_valid), 0);
    check("rst_full",  32'(full), 0);
    check("rst_v1",    alu_v1, 0);
    check("rst_rob",   32'(alu_rob_id), 0);
    @(negedge clk);
    rst_n = 1;

    // Both operands ready: issued one edge after dispatch
    set_disp(3, 0, 0, 5, 0, 0, 7);
    tick();
    check("t1_not_yet", 32'(alu_valid), 0);
    idle();
    tick();
    check("t1_valid", 32'(alu_valid), 1);
    check("t1_rob",   32'(alu_rob_id), 3);
    check("t1_v1",    alu_v1, 5);
    check("t1_v2",    alu_v2, 7);
    check("t1_op",    32'(alu_op), 0);
    tick();
    check("t1_drop",  32'(alu_valid), 0);

    // qj pending on tag 2, woken by the ALU bus
    set_disp(4, 1, 2, 0, 0, 0, 3);
    tick();
    idle();
    tick();
    tick();
    cdb_alu_valid = 1; cdb_alu_rob_id = 2; cdb_alu_result = 32'h10;
    tick();
`ifdef RS_WAKEUP_BYPASS_EN
    check("t2_valid", 32'(alu_valid), 1);
    check("t2_v1",    alu_v1, 32'h10);
    idle();
    tick();
    check("t2_drop",  32'(alu_valid), 0);
`else
    check("t2_wait",  32'(alu_valid), 0);
    idle();
    tick();
    check("t2_valid", 32'(alu_valid), 1);
    check("t2_rob",   32'(alu_rob_id), 4);
    check("t2_v1",    alu_v1, 32'h10);
`endif

    // qk forwarded from the LSB bus in the dispatch cycle
    set_disp(5, 0, 0, 9, 1, 6, 0);
    cdb_lsb_valid = 1; cdb_lsb_rob_id = 6; cdb_lsb_result = 32'hFF;
    tick();
    idle();
    tick();
    check("t3_valid", 32'(alu_valid), 1);
    check("t3_rob",   32'(alu_rob_id), 5);
    check("t3_v2",    alu_v2, 32'hFF);

    // Fill all entries with pending ops
    for (int i = 0; i < N; i++) begin
      set_disp(i, 1, 8 + i, 0, 0, 0, i);
      tick();
    end
    check("t4_full", 32'(full), 1);
    set_disp(9, 0, 0, 1, 0, 0, 1);
    tick();
    check("t4_still_full", 32'(full), 1);
    idle();
    tick();
    check("t4_ninth_ignored", 32'(alu_valid), 0);
    cdb_alu_valid = 1; cdb_alu_rob_id = 13; cdb_alu_result = 32'h55;
    tick();
`ifdef RS_WAKEUP_BYPASS_EN
    check("t4_valid", 32'(alu_valid), 1);
    check("t4_rob",   32'(alu_rob_id), 5);
    check("t4_free",  32'(full), 0);
    idle();
    tick();
`else
    check("t4_full_hold", 32'(full), 1);
    idle();
    tick();
    check("t4_valid", 32'(alu_valid), 1);
    check("t4_rob",   32'(alu_rob_id), 5);
    check("t4_v1",    alu_v1, 32'h55);
    check("t4_free",  32'(full), 0);
`endif

    // Flush: the discarded dispatch and wakeup must leave nothing behind
    rob_clear = 1;
    set_disp(10, 0, 0, 1, 0, 0, 1);
    cdb_alu_valid = 1; cdb_alu_rob_id = 8; cdb_alu_result = 32'h1;
    tick();
    idle();
    check("t6_clr_valid", 32'(alu_valid), 0);
    check("t6_clr_full",  32'(full), 0);
    for (int t = 8; t < 16; t++) begin
      cdb_alu_valid = 1; cdb_alu_rob_id = RW'(t); cdb_alu_result = 32'(t);
      tick();
      check("t6_no_issue", 32'(alu_valid), 0);
    end
    idle();

    // Two entries woken together issue lowest index first
    set_disp(1, 1, 9, 0, 0, 0, 32'h11);
    tick();
    set_disp(2, 1, 9, 0, 0, 0, 32'h22);
    tick();
    idle();
    cdb_alu_valid = 1; cdb_alu_rob_id = 9; cdb_alu_result = 32'h99;
    tick();
    idle();
`ifdef RS_WAKEUP_BYPASS_EN
    check("t5_first", 32'(alu_rob_id), 1);
    tick();
    check("t5_second", 32'(alu_rob_id), 2);
`else
    check("t5_wait", 32'(alu_valid), 0);
    tick();
    check("t5_first", 32'(alu_rob_id), 1);
    tick();
    check("t5_second", 32'(alu_rob_id), 2);
`endif
    check("t5_valid", 32'(alu_valid), 1);
    tick();

    // rdy low freezes a ready entry
    set_disp(7, 0, 0, 1, 0, 0, 2);
    tick();
    idle();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t7_frozen", 32'(alu_valid), 0);
    end
    rdy = 1;
    tick();
    check("t7_valid", 32'(alu_valid), 1);
    check("t7_rob",   32'(alu_rob_id), 7);

    // Asynchronous reset mid-cycle
    set_disp(3, 0, 0, 4, 0, 0, 4);
    tick();
    idle();
    tick();
    check("t8_pre", 32'(alu_valid), 1);
    #2 rst_n = 0;
    #1;
    check("t8_valid", 32'(alu_valid), 0);
    check("t8_rob",   32'(alu_rob_id), 0);
    check("t8_full",  32'(full), 0);
    m_reset();
    #3 rst_n = 1;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rdy             = ($urandom_range(0, 9) != 0);
      rob_clear       = ($urandom_range(0, 39) == 0);
      disp_valid      = $urandom_range(0, 1);
      disp_rob_id     = RW'($urandom);
      disp_op         = 3'($urandom);
      disp_instr_type = ($urandom_range(0, 1) != 0) ? OP_IMM : OP_BRANCH;
      disp_op_other   = $urandom_range(0, 1);
      disp_qj_pending = $urandom_range(0, 1);
      disp_qk_pending = $urandom_range(0, 1);
      disp_qj         = RW'($urandom_range(0, 7));
      disp_qk         = RW'($urandom_range(0, 7));
      disp_vj         = $urandom;
      disp_vk         = $urandom;
      cdb_alu_valid   = $urandom_range(0, 1);
      cdb_alu_rob_id  = RW'($urandom_range(0, 7));
      cdb_alu_result  = $urandom;
      cdb_lsb_valid   = $urandom_range(0, 1);
      cdb_lsb_rob_id  = RW'($urandom_range(0, 7));
      cdb_lsb_result  = $urandom;
      if (cdb_alu_valid && cdb_lsb_valid && cdb_alu_rob_id == cdb_lsb_rob_id) cdb_lsb_valid = 0;
      tick();
    end
    idle();
    rdy = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that feeds the ALU in the Tomasulo-style out-of-order core; it is the issuing end of the ALU request interface.
- Accepts dispatched integer and branch ops from the decoder/dispatch stage and holds them until both operands are known.
- Snoops the ALU and LSB result broadcasts (CDB) to wake up pending operands.
- Issues one ready op per cycle to the ALU as a registered request.

Parameters:
- RS_SIZE, 8, number of entries; power of two, 2..16.
- ROB_W, `ROB_SIZE_WIDTH, width of ROB tags.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global clock-enable; when low, all state holds.
- rob_clear  in  1  mispredict flush; synchronous, takes priority over everything except rst_n.
- disp_valid  in  1  dispatch request this cycle.
- disp_rob_id  in  ROB_W  destination ROB tag.
- disp_op  in  3  funct3.
- disp_instr_type  in  7  opcode (0010011 / 0110011 / 1100011).
- disp_op_other  in  1  funct7[5] sub/sra select.
- disp_qj_pending, disp_qk_pending  in  1 each  operand still awaited.
- disp_qj, disp_qk  in  ROB_W each  producer tags.
- disp_vj, disp_vk  in  32 each  operand values when not pending.
- full  out  1  combinational; all entries busy.
- cdb_alu_valid / cdb_alu_rob_id / cdb_alu_result  in  1/ROB_W/32  ALU broadcast.
- cdb_lsb_valid / cdb_lsb_rob_id / cdb_lsb_result  in  1/ROB_W/32  LSB broadcast.
- alu_valid, alu_rob_id, alu_op, alu_instr_type, alu_op_other, alu_v1, alu_v2  out  1/ROB_W/3/7/1/32/32  registered ALU request.

Behaviour:
- Reset: all busy bits 0. All alu_* outputs 0. full = 0.
- Entry fields: busy, rob_id, op, instr_type, op_other, qj_pending, qj, vj, qk_pending, qk, vk.
- Dispatch (rdy & disp_valid & !full):
  - Written into the lowest-index non-busy entry, computed from current-cycle busy bits.
  - A slot freed by an issue in the same cycle is not reusable until the next cycle.
  - Same-cycle CDB forwarding: if a pending operand's tag matches a valid CDB bus this cycle, store the CDB value with pending = 0.
- Dispatch while full: ignored, no state change. Upstream must check full.
- Wakeup: every cycle (rdy high), each busy entry with pending q equal to a valid CDB tag latches that result and clears pending.
  - Both buses matching the same tag is illegal; ALU bus wins if it occurs.
- Ready and select:
  - ready[i] = busy & !qj_pending & !qk_pending, from registered state.
  - Select the lowest-index ready entry.
  - On the edge: load alu_* from it, set alu_valid = 1, clear its busy bit.
  - No ready entry: alu_valid <= 0; other alu_* fields hold.
- Latency:
  - Dispatch with both operands ready at edge N → alu_valid high after edge N+1 → ALU result after N+2.
  - CDB wakeup at edge N → issuable at edge N+1.
- rob_clear (rdy high): all busy <= 0, alu_valid <= 0; dispatch and wakeup that cycle are discarded.
- rdy low: no dispatch, wakeup, issue or clear; alu_* outputs hold their values.
- rst_n low mid-operation: immediate, asynchronous return to reset values.

Optional Feature:
- Macro RS_WAKEUP_BYPASS_EN.
- Defined:
  - ready[i] also counts operands whose tag matches a valid CDB bus this cycle.
  - The issued operand is muxed from the CDB value, so wakeup at edge N → issue at edge N.
  - The stored entry is still updated if the entry is not issued.
- Undefined: one-cycle wakeup-to-issue latency as specified above.

Decomposition:
- Shared package/config: ROB_SIZE_WIDTH, RS_SIZE default, opcode constants OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_BRANCH = 7'b1100011, RS entry field widths.
- Sub-module rs_select: parameterized lowest-index priority encoder.
  - Inputs: busy and ready vectors.
  - Outputs: free_idx/free_found and issue_idx/issue_found.
  - Instantiated once.

Test Plan:
- Reset, dispatch ADD rob=3, vj=5, vk=7 both ready, op=000 → one cycle later alu_valid=1, alu_rob_id=3, alu_v1=5, alu_v2=7; following cycle alu_valid=0.
- Dispatch rob=4 with qj pending on tag 2; two cycles later cdb_alu rob=2 result=0x10 → issue next edge with alu_v1=0x10 (same edge with RS_WAKEUP_BYPASS_EN).
- Dispatch with qk pending on tag 6 in the same cycle cdb_lsb rob=6 result=0xFF → entry stored ready, issued next edge with alu_v2=0xFF.
- Fill 8 entries all pending → full=1; 9th dispatch ignored; wake entry 5 → issued, full=0 the cycle after.
- Two ready entries at indices 0 (rob=1) and 1 (rob=2) → alu_rob_id=1 then 2 on consecutive cycles.
- Three busy entries, assert rob_clear → next cycle alu_valid=0, full=0, later CDB tags cause no issue; rdy low 3 cycles with a ready entry → no issue until rdy returns.
